// File: rtl/split_ctrl_pkg.sv
// Shared types and helpers for the split sampler controller.
// Optional build macro used by the controller: SPLIT_CTRL_STATS_EN.
package split_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    WAIT,
    CHECK,
    OUT
  } state_t;

  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h80200003;

  // Number of 32-bit LFSR words needed to cover a candidate vector.
  function automatic int nwords(input int cand_w);
    return (cand_w + LFSR_W - 1) / LFSR_W;
  endfunction

endpackage

// File: rtl/split_lfsr32.sv
// 32-bit Galois LFSR (right shift) with seed load and zero-seed fixup.
// next_value is the value the register takes on a step; the controller
// writes it straight into the candidate so the word and the LFSR agree.
module split_lfsr32
  import split_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] next_value
);

  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] seed_fixed;

  // One Galois step of the current state; a zero seed would lock up, so use 1.
  always_comb begin
    next_value = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_POLY) : (lfsr_reg >> 1);
    seed_fixed = (seed == '0) ? LFSR_W'(1) : seed;
  end

  // State register: load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= '0;
    end else if (load) begin
      lfsr_reg <= seed_fixed;
    end else if (step) begin
      lfsr_reg <= next_value;
    end
  end

endmodule

// File: rtl/split_sampler_ctrl.sv
// Sequencer for a bank of split constraint checkers: fills a candidate
// vector word by word from an LFSR, waits for the checkers to settle,
// ANDs their verdicts and retries until success or the try budget ends.
// Optional build macro: SPLIT_CTRL_STATS_EN adds per-split reject counters.
module split_sampler_ctrl
  import split_ctrl_pkg::*;
#(
  parameter int CAND_W     = 232,
  parameter int NUM_SPLITS = 10,
  parameter int EVAL_LAT   = 1,
  parameter int MAX_TRIES  = 1024,
  parameter int TRY_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic [CAND_W-1:0]     cand,
  input  logic [NUM_SPLITS-1:0] split_x,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CAND_W-1:0]     res_data,
  output logic                  res_fail,
  output logic [TRY_W-1:0]      tries
`ifdef SPLIT_CTRL_STATS_EN
  ,
  output logic [NUM_SPLITS*16-1:0] rej_cnt
`endif
);

  localparam int NWORDS = nwords(CAND_W);
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int WCNT_W = (EVAL_LAT > 0) ? $clog2(EVAL_LAT + 1) : 1;

  state_t state_reg, state_next;

  logic [WIDX_W-1:0] word_idx_reg;
  logic [WCNT_W-1:0] wcnt_reg;
  logic [TRY_W-1:0]  tries_reg;
  logic              res_fail_reg;
  logic [CAND_W-1:0] cand_reg;
  wire  [CAND_W-1:0] cand_next;

  logic [LFSR_W-1:0] lfsr_next;
  logic              start_load;
  logic              gen_step;
  logic              last_word;
  logic              all_ok;
  logic              last_try;
  logic              fail_check;

  // Decode of the current state into datapath controls.
  always_comb begin
    start_load = (state_reg == IDLE) && start;
    gen_step   = (state_reg == GEN);
    last_word  = (word_idx_reg == WIDX_W'(NWORDS - 1));
    all_ok     = &split_x;
    last_try   = ((tries_reg + 1'b1) == TRY_W'(MAX_TRIES));
    fail_check = (state_reg == CHECK) && !all_ok;
  end

  split_lfsr32 u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (start_load),
    .step       (gen_step),
    .seed       (seed),
    .next_value (lfsr_next)
  );

  // Per-word candidate update: only the word selected in GEN takes the new
  // LFSR value; the top word keeps just the bits that exist.
  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
    localparam int WORD_W = (gi == NWORDS - 1) ? (CAND_W - 32 * gi) : 32;
    assign cand_next[32*gi +: WORD_W] =
      (gen_step && (word_idx_reg == WIDX_W'(gi))) ? lfsr_next[WORD_W-1:0]
                                                  : cand_reg[32*gi +: WORD_W];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = GEN;
      end
      GEN: begin
        if (last_word) state_next = (EVAL_LAT == 0) ? CHECK : WAIT;
      end
      WAIT: begin
        if (wcnt_reg <= WCNT_W'(1)) state_next = CHECK;
      end
      CHECK: begin
        if (all_ok || last_try) state_next = OUT;
        else                    state_next = GEN;
      end
      OUT: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: word index, settle counter, try counter, verdict and candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx_reg <= '0;
      wcnt_reg     <= '0;
      tries_reg    <= '0;
      res_fail_reg <= 1'b0;
      cand_reg     <= '0;
    end else begin
      cand_reg <= cand_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            word_idx_reg <= '0;
            tries_reg    <= '0;
            res_fail_reg <= 1'b0;
          end
        end
        GEN: begin
          if (last_word) begin
            word_idx_reg <= '0;
            wcnt_reg     <= WCNT_W'(EVAL_LAT);
          end else begin
            word_idx_reg <= word_idx_reg + 1'b1;
          end
        end
        WAIT: begin
          wcnt_reg <= wcnt_reg - 1'b1;
        end
        CHECK: begin
          if (tries_reg != TRY_W'(MAX_TRIES)) tries_reg <= tries_reg + 1'b1;
          if (all_ok)        res_fail_reg <= 1'b0;
          else if (last_try) res_fail_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SPLIT_CTRL_STATS_EN
  wire [NUM_SPLITS*16-1:0] rej_flat;

  for (genvar gi = 0; gi < NUM_SPLITS; gi++) begin : g_rej
    logic [15:0] cnt_reg;

    // Count failed checks where this split was unsatisfied, saturating.
    always_ff @(posedge clk) begin
      if (rst || start_load) begin
        cnt_reg <= '0;
      end else if (fail_check && !split_x[gi] && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end

    assign rej_flat[16*gi +: 16] = cnt_reg;
  end

  assign rej_cnt = rej_flat;
`endif

  assign busy      = (state_reg != IDLE);
  assign res_valid = (state_reg == OUT);
  assign cand      = cand_reg;
  assign res_data  = cand_reg;
  assign res_fail  = res_fail_reg;
  assign tries     = tries_reg;

endmodule

// File: tb/tb_split_sampler_ctrl.sv
// Self-checking bench for split_sampler_ctrl. Two instances: A is a
// single-word, zero-latency build; B is the 232-bit, EVAL_LAT=1,
// MAX_TRIES=4 build. Expected results are queued at start and compared
// when res_valid appears.
module tb_split_sampler_ctrl;

  localparam int AW = 32;
  localparam int BW = 232;
  localparam int NS = 10;
  localparam int TW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic          rst_a, start_a, res_ready_a;
  logic [31:0]   seed_a;
  logic [NS-1:0] split_x_a;
  logic          busy_a, res_valid_a, res_fail_a;
  logic [AW-1:0] cand_a, res_data_a;
  logic [TW-1:0] tries_a;

  // Instance B signals
  logic          rst_b, start_b, res_ready_b;
  logic [31:0]   seed_b;
  logic [NS-1:0] split_x_b;
  logic          busy_b, res_valid_b, res_fail_b;
  logic [BW-1:0] cand_b, res_data_b;
  logic [TW-1:0] tries_b;

`ifdef SPLIT_CTRL_STATS_EN
  logic [NS*16-1:0] rej_cnt_a, rej_cnt_b;
`endif

  split_sampler_ctrl #(
    .CAND_W(AW), .NUM_SPLITS(NS), .EVAL_LAT(0), .MAX_TRIES(1024), .TRY_W(TW)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .seed(seed_a), .busy(busy_a),
    .cand(cand_a), .split_x(split_x_a), .res_valid(res_valid_a),
    .res_ready(res_ready_a), .res_data(res_data_a), .res_fail(res_fail_a),
    .tries(tries_a)
`ifdef SPLIT_CTRL_STATS_EN
    , .rej_cnt(rej_cnt_a)
`endif
  );

  split_sampler_ctrl #(
    .CAND_W(BW), .NUM_SPLITS(NS), .EVAL_LAT(1), .MAX_TRIES(4), .TRY_W(TW)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .seed(seed_b), .busy(busy_b),
    .cand(cand_b), .split_x(split_x_b), .res_valid(res_valid_b),
    .res_ready(res_ready_b), .res_data(res_data_b), .res_fail(res_fail_b),
    .tries(tries_b)
`ifdef SPLIT_CTRL_STATS_EN
    , .rej_cnt(rej_cnt_b)
`endif
  );

  typedef struct {
    logic [BW-1:0] data;
    logic          fail;
    logic [TW-1:0] tries;
    int            lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;

  // Reference LFSR step.
  function automatic logic [31:0] m_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  // Candidate produced by the ntries-th GEN pass from a given seed.
  function automatic logic [255:0] m_cand(input logic [31:0] seed, input int nw,
                                          input int ntries);
    logic [31:0]  s;
    logic [255:0] buf_v;
    s = (seed == 32'd0) ? 32'd1 : seed;
    buf_v = '0;
    for (int t = 0; t < ntries; t++) begin
      for (int w = 0; w < nw; w++) begin
        s = m_step(s);
        buf_v[32*w +: 32] = s;
      end
    end
    return buf_v;
  endfunction

  task automatic push_exp(input int sel, input logic [BW-1:0] d, input logic f,
                          input int t, input int lat);
    exp_t e;
    e.data  = d;
    e.fail  = f;
    e.tries = TW'(t);
    e.lat   = lat;
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  // Present start for exactly one rising edge; returns at the negedge after it.
  task automatic drive_start(input int sel, input logic [31:0] s);
    @(negedge clk);
    if (sel == 0) begin seed_a = s; start_a = 1'b1; end
    else          begin seed_b = s; start_b = 1'b1; end
    @(negedge clk);
    if (sel == 0) start_a = 1'b0;
    else          start_b = 1'b0;
  endtask

  // Wait (bounded) for res_valid, pop the scoreboard and compare.
  // c0 = edges since start already elapsed; ones_at = edge after which
  // split_x is forced all-ones (0 = never).
  task automatic collect(input int sel, input int c0, input int ones_at);
    int            c;
    bit            seen;
    exp_t          e;
    logic [BW-1:0] obs_d;
    logic          obs_f;
    logic [TW-1:0] obs_t;
    c = c0;
    seen = 1'b0;
    while (c < c0 + 200) begin
      if ((sel == 0) ? res_valid_a : res_valid_b) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      c++;
      if (ones_at != 0 && c == ones_at) begin
        if (sel == 0) split_x_a = '1;
        else          split_x_b = '1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL res_valid_timeout dut=%0d waited %0d cycles", sel, c);
      return;
    end
    if ((sel == 0 ? q_a.size() : q_b.size()) == 0) begin
      errors++;
      $display("FAIL scoreboard_empty dut=%0d unexpected result", sel);
      return;
    end
    e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
    obs_d = (sel == 0) ? {{(BW-AW){1'b0}}, res_data_a} : res_data_b;
    obs_f = (sel == 0) ? res_fail_a : res_fail_b;
    obs_t = (sel == 0) ? tries_a : tries_b;
    $display("result dut=%0d lat=%0d tries=%0d fail=%0b data=%h", sel, c, obs_t,
             obs_f, obs_d);
    checks++;
    if (obs_d !== e.data) begin
      errors++;
      $display("FAIL res_data dut=%0d got %h want %h", sel, obs_d, e.data);
    end
    checks++;
    if (obs_f !== e.fail) begin
      errors++;
      $display("FAIL res_fail dut=%0d got %0b want %0b", sel, obs_f, e.fail);
    end
    checks++;
    if (obs_t !== e.tries) begin
      errors++;
      $display("FAIL tries dut=%0d got %0d want %0d", sel, obs_t, e.tries);
    end
    checks++;
    if (c != e.lat) begin
      errors++;
      $display("FAIL latency dut=%0d got %0d want %0d", sel, c, e.lat);
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    seed_a = '0; seed_b = '0;
    split_x_a = '0; split_x_b = '0;
    res_ready_a = 1'b1; res_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    checks++;
    if ({busy_a, res_valid_a, res_fail_a, cand_a, res_data_a, tries_a} !== '0 ||
        {busy_b, res_valid_b, res_fail_b, cand_b, res_data_b, tries_b} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%0b/%0b valid=%0b/%0b tries=%0d/%0d want all 0",
               busy_a, busy_b, res_valid_a, res_valid_b, tries_a, tries_b);
    end
    $display("reset done");
  endtask

  task automatic test_first_solve;
    split_x_a = '1;
    res_ready_a = 1'b1;
    push_exp(0, BW'(32'h80200003), 1'b0, 1, 3);
    drive_start(0, 32'd1);
    checks++;
    if (busy_a !== 1'b1 || cand_a !== '0) begin
      errors++;
      $display("FAIL first_gen_entry busy=%0b cand=%h want busy=1 cand=0", busy_a, cand_a);
    end
    @(negedge clk);
    checks++;
    if (cand_a !== 32'h80200003 || res_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL first_cand got %h valid=%0b want 80200003 valid=0", cand_a, res_valid_a);
    end
    collect(0, 2, 0);
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || res_valid_a !== 1'b0 || tries_a !== 16'd1) begin
      errors++;
      $display("FAIL first_idle busy=%0b valid=%0b tries=%0d want 0 0 1",
               busy_a, res_valid_a, tries_a);
    end
  endtask

  task automatic test_seed_zero;
    logic [31:0]  seq [2][9];
    logic [255:0] m;
    logic [31:0]  s;
    int           c;
    for (int r = 0; r < 2; r++) begin
      s = (r == 0) ? 32'd1 : 32'd0;
      split_x_a = '0;
      m = m_cand(s, 1, 4);
      push_exp(0, BW'(m[31:0]), 1'b0, 4, 9);
      drive_start(0, s);
      c = 1;
      while (c < 8) begin
        @(negedge clk);
        c++;
        seq[r][c] = cand_a;
        if (c == 8) split_x_a = '1;
      end
      collect(0, 8, 0);
    end
    for (int k = 2; k <= 8; k++) begin
      m = m_cand(32'd1, 1, k / 2);
      checks++;
      if (seq[0][k] !== m[31:0] || seq[1][k] !== seq[0][k]) begin
        errors++;
        $display("FAIL seed0_seq cycle=%0d seed1=%h seed0=%h want %h",
                 k, seq[0][k], seq[1][k], m[31:0]);
      end
    end
    $display("seed0 vs seed1 sequence compared over 7 cycles");
  endtask

  task automatic test_budget_fail;
    logic [255:0] m;
    split_x_b = '0;
    res_ready_b = 1'b1;
    m = m_cand(32'h12345678, 8, 4);
    push_exp(1, m[BW-1:0], 1'b1, 4, 41);
    drive_start(1, 32'h12345678);
    collect(1, 1, 0);
`ifdef SPLIT_CTRL_STATS_EN
    for (int k = 0; k < NS; k++) begin
      checks++;
      if (rej_cnt_b[16*k +: 16] !== 16'd4) begin
        errors++;
        $display("FAIL rej_cnt split=%0d got %0d want 4", k, rej_cnt_b[16*k +: 16]);
      end
    end
`endif
    @(negedge clk);
    checks++;
    if (busy_b !== 1'b0 || tries_b !== 16'd4) begin
      errors++;
      $display("FAIL fail_idle busy=%0b tries=%0d want 0 4", busy_b, tries_b);
    end
  endtask

  task automatic test_late_success;
    logic [255:0] m;
    split_x_b = 10'h3FE;
    m = m_cand(32'hCAFEF00D, 8, 3);
    push_exp(1, m[BW-1:0], 1'b0, 3, 31);
    drive_start(1, 32'hCAFEF00D);
    collect(1, 1, 21);
`ifdef SPLIT_CTRL_STATS_EN
    checks++;
    if (rej_cnt_b[15:0] !== 16'd2 || rej_cnt_b[NS*16-1:16] !== '0) begin
      errors++;
      $display("FAIL rej_cnt_late got split0=%0d want 2, others 0", rej_cnt_b[15:0]);
    end
`endif
  endtask

  task automatic test_backpressure;
    logic [255:0] m;
    m = m_cand(32'h0BADBEEF, 1, 1);
    split_x_a = '1;
    res_ready_a = 1'b0;
    push_exp(0, BW'(m[31:0]), 1'b0, 1, 3);
    drive_start(0, 32'h0BADBEEF);
    collect(0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start_a = (i % 3 == 0);
      checks++;
      if (res_valid_a !== 1'b1 || res_data_a !== m[31:0] || tries_a !== 16'd1) begin
        errors++;
        $display("FAIL hold cycle=%0d valid=%0b data=%h tries=%0d want 1 %h 1",
                 i, res_valid_a, res_data_a, tries_a, m[31:0]);
      end
    end
    @(negedge clk);
    res_ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (res_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL release valid=%0b busy=%0b want 0 0", res_valid_a, busy_a);
    end
    $display("backpressure held 20 cycles, released");
  endtask

  task automatic test_reset_mid_wait;
    logic [255:0] m;
    split_x_b = '0;
    drive_start(1, 32'h5A5A0001);
    repeat (18) @(negedge clk);
    m = m_cand(32'h5A5A0001, 8, 2);
    checks++;
    if (busy_b !== 1'b1 || tries_b !== 16'd1 || cand_b !== m[BW-1:0]) begin
      errors++;
      $display("FAIL pre_reset busy=%0b tries=%0d cand=%h want 1 1 %h",
               busy_b, tries_b, cand_b, m[BW-1:0]);
    end
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    checks++;
    if ({busy_b, res_valid_b, res_fail_b, cand_b, res_data_b, tries_b} !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%0b valid=%0b tries=%0d cand=%h want all 0",
               busy_b, res_valid_b, tries_b, cand_b);
    end
`ifdef SPLIT_CTRL_STATS_EN
    checks++;
    if (rej_cnt_b !== '0) begin
      errors++;
      $display("FAIL mid_reset_rej got %h want 0", rej_cnt_b);
    end
`endif
    split_x_b = '1;
    m = m_cand(32'h5A5A0001, 8, 1);
    push_exp(1, m[BW-1:0], 1'b0, 1, 11);
    drive_start(1, 32'h5A5A0001);
    collect(1, 1, 0);
  endtask

  initial begin
    test_reset;
    test_first_solve;
    test_seed_zero;
    test_budget_fail;
    test_late_success;
    test_backpressure;
    test_reset_mid_wait;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
